// File: rtl/mode_switch_controller.sv
// Mode-change sequencer for the display datapath: synchronizes and debounces SW[1:0],
// then commits the new mode on a frame boundary with a detector clear and a blanking window.
module mode_switch_controller #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BLANK_FRAMES    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sw_in,
  input  logic       frame_start,
  output logic [1:0] mode_out,
  output logic       detector_clear,
  output logic       output_blank,
  output logic       busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int BW = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, BLANK} state_t;

  logic [1:0]    sync1_reg, sw_s_reg, sw_norm;
  logic [1:0]    cand_reg, stable_reg, pending_reg;
  logic [CW-1:0] cnt_reg;
  logic [BW-1:0] bcnt_reg;
  state_t        state_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg <= 2'b00;
      sw_s_reg  <= 2'b00;
    end else begin
      sync1_reg <= sw_in;
      sw_s_reg  <= sync1_reg;
    end
  end

  // Both 10 and 11 select ASCII, so fold them before debouncing.
  assign sw_norm = (sw_s_reg == 2'b11) ? 2'b10 : sw_s_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand_reg   <= 2'b00;
      cnt_reg    <= '0;
      stable_reg <= 2'b00;
    end else if (sw_norm != cand_reg) begin
      cand_reg <= sw_norm;
      cnt_reg  <= '0;
    end else if (cnt_reg != CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt_reg <= cnt_reg + CW'(1);
    end else begin
      stable_reg <= cand_reg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      pending_reg    <= 2'b00;
      bcnt_reg       <= '0;
      mode_out       <= 2'b00;
      detector_clear <= 1'b0;
      output_blank   <= 1'b0;
      busy           <= 1'b0;
    end else begin
      detector_clear <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (stable_reg != mode_out) begin
            pending_reg <= stable_reg;
            state_reg   <= WAIT_FRAME;
            busy        <= 1'b1;
          end
        end
        WAIT_FRAME: begin
          if (stable_reg == mode_out) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else begin
            pending_reg <= stable_reg;
            // The commit uses the pending value held during the frame_start cycle.
            if (frame_start) begin
              mode_out       <= pending_reg;
              detector_clear <= 1'b1;
              if (BLANK_FRAMES == 0) begin
                state_reg <= IDLE;
                busy      <= 1'b0;
              end else begin
                bcnt_reg     <= BW'(BLANK_FRAMES);
                state_reg    <= BLANK;
                output_blank <= 1'b1;
              end
            end
          end
        end
        BLANK: begin
          if (frame_start) begin
            bcnt_reg <= bcnt_reg - BW'(1);
            if (bcnt_reg == BW'(1)) begin
              state_reg    <= IDLE;
              output_blank <= 1'b0;
              busy         <= 1'b0;
            end
          end
        end
        default: begin
          state_reg    <= IDLE;
          output_blank <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mode_switch_controller.sv
// Scoreboard bench for mode_switch_controller: a behavioural model predicts outputs every cycle
// and each commit; a negedge monitor pops and compares against the DUT.
module tb_mode_switch_controller;

  localparam int D = 16;
  localparam int B = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] sw_in = 2'b10;
  logic       frame_start = 1'b0;
  logic [1:0] mode_out;
  logic       detector_clear, output_blank, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int n_commit = 0;

  mode_switch_controller #(.DEBOUNCE_CYCLES(D), .BLANK_FRAMES(B)) dut (
    .clk(clk), .reset(reset), .sw_in(sw_in), .frame_start(frame_start),
    .mode_out(mode_out), .detector_clear(detector_clear),
    .output_blank(output_blank), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: stable = value seen for D+1 consecutive samples (two-sample sync lag),
  // a change waits for a frame, commits, then blanks B frames.
  logic [1:0] hist[$];
  logic [4:0] exp_vec[$];
  logic [1:0] exp_commit[$];
  logic [1:0] m_stable, m_mode, m_pend;
  bit         m_wait;
  int         m_blank;

  always @(posedge clk) begin
    logic       clr;
    logic       same;
    logic [1:0] s;
    clr = 1'b0;
    if (!reset) begin
      hist.delete();
      for (int i = 0; i < D + 3; i++) hist.push_back(2'b00);
      exp_commit.delete();
      m_stable = 2'b00; m_mode = 2'b00; m_pend = 2'b00; m_wait = 0; m_blank = 0;
    end else begin
      if (m_blank > 0) begin
        if (frame_start) m_blank = m_blank - 1;
      end else if (!m_wait) begin
        if (m_stable != m_mode) begin
          m_wait = 1;
          m_pend = m_stable;
        end
      end else if (m_stable == m_mode) begin
        m_wait = 0;
      end else begin
        if (frame_start) begin
          m_mode = m_pend;
          clr = 1'b1;
          m_wait = 0;
          m_blank = B;
          exp_commit.push_back(m_pend);
        end
        m_pend = m_stable;
      end
      s = (sw_in == 2'b11) ? 2'b10 : sw_in;
      hist.push_back(s);
      if (hist.size() > D + 3) void'(hist.pop_front());
      same = 1'b1;
      for (int k = 1; k <= D; k++) if (hist[k] != hist[0]) same = 1'b0;
      if (same) m_stable = hist[0];
    end
    exp_vec.push_back({m_mode, clr, (m_blank > 0), (m_wait || m_blank > 0)});
  end

  // Monitor
  always @(negedge clk) begin
    logic [4:0] e;
    logic [1:0] em;
    if (exp_vec.size() > 0) begin
      e = exp_vec.pop_front();
      n_cmp++;
      if ({mode_out, detector_clear, output_blank, busy} !== e) begin
        n_bad++;
        $display("FAIL outputs t=%0t got mode=%b clr=%b blank=%b busy=%b expected mode=%b clr=%b blank=%b busy=%b",
                 $time, mode_out, detector_clear, output_blank, busy, e[4:3], e[2], e[1], e[0]);
      end
    end
    if (detector_clear === 1'b1) begin
      n_cmp++;
      if (exp_commit.size() == 0) begin
        n_bad++;
        $display("FAIL commit t=%0t got unexpected clear with mode=%b expected no commit", $time, mode_out);
      end else begin
        em = exp_commit.pop_front();
        n_commit++;
        if (mode_out !== em) begin
          n_bad++;
          $display("FAIL commit t=%0t got mode=%b expected %b", $time, mode_out, em);
        end else begin
          $display("commit %0d t=%0t mode=%b", n_commit, $time, mode_out);
        end
      end
    end
  end

  int frame_ctr = 30;
  bit auto_frames = 0;

  task automatic tick(input logic fs);
    @(negedge clk);
    if (auto_frames) begin
      frame_ctr--;
      frame_start = (frame_ctr == 0);
      if (frame_ctr == 0) frame_ctr = $urandom_range(20, 50);
    end else begin
      frame_start = fs;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  task automatic async_reset(input logic [1:0] sw_during);
    @(negedge clk);
    frame_start = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({mode_out, detector_clear, output_blank, busy} !== 5'b0) begin
      n_bad++;
      $display("FAIL async_reset got mode=%b clr=%b blank=%b busy=%b expected all 0",
               mode_out, detector_clear, output_blank, busy);
    end
    sw_in = sw_during;
    idle(3);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // Glitch rejection out of reset
    sw_in = 2'b00;
    idle(3);
    reset = 1'b1;
    idle(3);
    sw_in = 2'b01; idle(10);
    sw_in = 2'b00; idle(30);
    // Reset with switches already at ASCII
    reset = 1'b0; sw_in = 2'b10;
    idle(3);
    reset = 1'b1;
    idle(25); tick(1); idle(10); tick(1); idle(5);
    // Normalization: 11 from 10 is no change
    sw_in = 2'b11; idle(30);
    sw_in = 2'b00; idle(25); tick(1); idle(5); tick(1); idle(3);
    sw_in = 2'b11; idle(25); tick(1); idle(5); tick(1); idle(3);
    sw_in = 2'b00; idle(25); tick(1); idle(5); tick(1); idle(3);
    // Clean commit to color
    sw_in = 2'b01; idle(39); tick(1); idle(59); tick(1); idle(5);
    // Cancel in WAIT_FRAME
    sw_in = 2'b10; idle(22);
    sw_in = 2'b01; idle(25);
    // Deferral of a change seen during BLANK
    sw_in = 2'b10; idle(22); tick(1); idle(5);
    sw_in = 2'b00; idle(30); tick(1); idle(5); tick(1); idle(3); tick(1); idle(3);
    // Async reset mid-BLANK, switches returned to normal
    sw_in = 2'b01; idle(22); tick(1); idle(3);
    async_reset(2'b00);
    idle(10); tick(1); idle(30); tick(1); idle(5);
    // Randomized segments with free-running frames
    auto_frames = 1;
    for (int seg = 0; seg < 70; seg++) begin
      sw_in = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) async_reset(2'($urandom_range(0, 3)));
      idle(($urandom_range(0, 2) == 0) ? $urandom_range(2, 14) : $urandom_range(18, 90));
    end
    auto_frames = 0;
    idle(3);
    n_cmp++;
    if (exp_commit.size() != 0) begin
      n_bad++;
      $display("FAIL missing_commits got %0d outstanding expected 0", exp_commit.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
